booth_r4_seq_ctrl: RTL and testbench
====================================

BOOTH_R4_SEQ_CTRL -- requirements
Module: booth_r4_seq_ctrl

Interface
REQ-001 Parameter OP_WIDTH, default 8, multiplier operand width; even, >=4.
REQ-002 Parameter SKIP_ZERO, default 1, selects whether zero Booth digits bypass the ADD state.
REQ-003 Derived ITERS = OP_WIDTH/2 in signed mode, OP_WIDTH/2+1 in unsigned mode; CNT_W = $clog2(OP_WIDTH/2+2).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-high.
REQ-006 start  in  1  begin an operation; sampled in IDLE only.
REQ-007 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured on the start edge.
REQ-008 abort  in  1  cancel the operation in flight.
REQ-009 q_bits  in  3  {q1,q0,q-1} Booth window from the datapath Q register.
REQ-010 load_a  out  1  load multiplicand (M) register.
REQ-011 load_q  out  1  load multiplier (Q) register and clear accumulator.
REQ-012 add_en  out  1  accumulator update enable.
REQ-013 dbl  out  1  select 2M operand.
REQ-014 neg  out  1  subtract (add complement).
REQ-015 shift_en  out  1  arithmetic right shift of {A,Q,q-1} by 2.
REQ-016 out_en  out  1  drive the product onto the result bus.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse; product is valid.
REQ-019 aborted  out  1  one-cycle pulse after an accepted abort.
REQ-020 iter_cnt  out  CNT_W  completed iterations.

Function
REQ-021 States: IDLE, LOAD_A, LOAD_Q, RECODE, ADD, SHIFT, OUT; all outputs decoded from state, with no combinational path from any input to any output except dbl/neg in ADD.
REQ-022 Transitions: IDLE->LOAD_A when start=1; LOAD_A->LOAD_Q; LOAD_Q->RECODE; RECODE->ADD if digit!=0 or SKIP_ZERO=0, otherwise RECODE->SHIFT; ADD->SHIFT; SHIFT->OUT if iter_cnt==ITERS-1, otherwise SHIFT->RECODE; OUT->IDLE.
REQ-023 Recode digit table:
- 000/111 = 0
- 001/010 = +1
- 011 = +2
- 100 = -2
- 101/110 = -1
REQ-024 Decode outputs:
- load_a=1 in LOAD_A; load_q=1 in LOAD_Q.
- add_en=1 in ADD only when digit!=0; dbl=1 for |digit|=2; neg=1 for negative digits.
- shift_en=1 in SHIFT; out_en=done=1 in OUT.
REQ-025 iter_cnt: cleared in LOAD_Q, incremented in SHIFT, holds otherwise; it never exceeds ITERS.
REQ-026 Unsigned mode: the datapath zero-extends the operands; the control unit runs one extra iteration, and its last digit is taken from q_bits unchanged.
REQ-027 Latency from the start edge to done: 3 + 2*ITERS + (number of ADD visits) cycles.
REQ-028 start while busy=1 is ignored.
REQ-029 start asserted in the OUT cycle does not start an operation; IDLE is always entered first.
REQ-030 abort=1 in any non-IDLE state: next state is IDLE, aborted=1 for that cycle, done stays 0.
REQ-031 abort has priority over every other transition.
REQ-032 abort=1 in IDLE has no effect, even together with start; in that case start wins.

Reset
REQ-033 rst=1 forces IDLE and iter_cnt=0 immediately, independent of clk.
REQ-034 While rst=1, every output is 0.
REQ-035 Reset mid-operation discards the operation and produces no done or aborted pulse.

Structure
REQ-036 Shared package booth_pkg holds the state encoding constants and the Booth digit encodings.
REQ-037 One sub-module, booth_r4_recoder: combinational, q_bits -> {nonzero, dbl, neg}.

Verification
REQ-038 OP_WIDTH=8, signed, SKIP_ZERO=1, all q_bits=000: done exactly 11 cycles after the start edge; add_en never 1.
REQ-039 Same configuration, q_bits=011 every iteration: 4 ADD cycles with dbl=1, neg=0; done at cycle 15.
REQ-040 OP_WIDTH=8, unsigned mode: 5 SHIFT pulses; iter_cnt reads 5 in OUT.
REQ-041 SKIP_ZERO=0, q_bits=000: ADD visited 4 times with add_en=0; done at cycle 15.
REQ-042 abort during the 2nd RECODE: IDLE next cycle, aborted pulse, no done; a following start completes normally.
REQ-043 rst pulse mid-SHIFT: outputs 0 immediately, state IDLE; start held during busy produces a single operation only.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequencer: FSM state encoding and
// the recoded digit format handed from the recoder to the control FSM.
package booth_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_Q = 3'd2,
        S_RECODE = 3'd3,
        S_ADD    = 3'd4,
        S_SHIFT  = 3'd5,
        S_OUT    = 3'd6
    } state_t;

    // A Booth digit in {-2,-1,0,+1,+2}, stored as magnitude flags plus sign.
    typedef struct packed {
        logic nonzero;
        logic dbl;
        logic neg;
    } digit_t;

    localparam digit_t DIG_ZERO = '{nonzero: 1'b0, dbl: 1'b0, neg: 1'b0};
    localparam digit_t DIG_P1   = '{nonzero: 1'b1, dbl: 1'b0, neg: 1'b0};
    localparam digit_t DIG_P2   = '{nonzero: 1'b1, dbl: 1'b1, neg: 1'b0};
    localparam digit_t DIG_M1   = '{nonzero: 1'b1, dbl: 1'b0, neg: 1'b1};
    localparam digit_t DIG_M2   = '{nonzero: 1'b1, dbl: 1'b1, neg: 1'b1};

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: maps the {q1,q0,q-1} window onto a
// signed digit expressed as nonzero/double/negate flags.
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] q_bits,
    output digit_t     digit
);

    always_comb begin
        digit = DIG_ZERO;
        unique case (q_bits)
            3'b001, 3'b010: digit = DIG_P1;
            3'b011:         digit = DIG_P2;
            3'b100:         digit = DIG_M2;
            3'b101, 3'b110: digit = DIG_M1;
            default:        digit = DIG_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_ctrl.sv
// Sequencing FSM for a radix-4 Booth multiplier datapath. Every output is a
// register loaded from the next-state decode, so nothing is combinational from inputs.
module booth_r4_seq_ctrl
    import booth_pkg::*;
#(
    parameter  int OP_WIDTH  = 8,
    parameter  bit SKIP_ZERO = 1'b1,
    localparam int CNT_W     = $clog2(OP_WIDTH / 2 + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             abort,
    input  logic [2:0]       q_bits,
    output logic             load_a,
    output logic             load_q,
    output logic             add_en,
    output logic             dbl,
    output logic             neg,
    output logic             shift_en,
    output logic             out_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] iter_cnt,
    output logic [2:0]       dbg_state
);

    localparam int ITERS_S = OP_WIDTH / 2;
    localparam int ITERS_U = OP_WIDTH / 2 + 1;

    state_t     state;
    state_t     nxt;
    logic       mode_signed;
    digit_t     digit;
    logic [CNT_W-1:0] last_iter;

    booth_r4_recoder u_recoder (
        .q_bits (q_bits),
        .digit  (digit)
    );

    // Unsigned operands are zero-extended by one digit, hence one extra pass.
    assign last_iter = mode_signed ? CNT_W'(ITERS_S - 1) : CNT_W'(ITERS_U - 1);
    assign dbg_state = state;

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:   if (start) nxt = S_LOAD_A;
            S_LOAD_A: nxt = S_LOAD_Q;
            S_LOAD_Q: nxt = S_RECODE;
            S_RECODE: nxt = (digit.nonzero || !SKIP_ZERO) ? S_ADD : S_SHIFT;
            S_ADD:    nxt = S_SHIFT;
            S_SHIFT:  nxt = (iter_cnt == last_iter) ? S_OUT : S_RECODE;
            S_OUT:    nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mode_signed <= 1'b1;
            iter_cnt    <= '0;
            load_a      <= 1'b0;
            load_q      <= 1'b0;
            add_en      <= 1'b0;
            dbl         <= 1'b0;
            neg         <= 1'b0;
            shift_en    <= 1'b0;
            out_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && start) mode_signed <= signed_mode;
            if (nxt == S_LOAD_Q) begin
                iter_cnt <= '0;
            end else if (state == S_SHIFT) begin
                iter_cnt <= iter_cnt + CNT_W'(1);
            end
            load_a   <= (nxt == S_LOAD_A);
            load_q   <= (nxt == S_LOAD_Q);
            // The digit is captured while leaving RECODE; Q is stable until SHIFT.
            add_en   <= (nxt == S_ADD) && digit.nonzero;
            dbl      <= (nxt == S_ADD) && digit.dbl;
            neg      <= (nxt == S_ADD) && digit.neg;
            shift_en <= (nxt == S_SHIFT);
            out_en   <= (nxt == S_OUT);
            done     <= (nxt == S_OUT);
            busy     <= (nxt != S_IDLE);
            aborted  <= abort && (state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Bench for booth_r4_seq_ctrl: two instances (zero-skip on/off) share control
// inputs; each sees its own q_bits stream, checked against a digit-level model.
module tb_booth_r4_seq_ctrl;
    import booth_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic signed_mode = 1'b1;
    logic abort = 1'b0;
    logic [1:0][2:0] qb;
    logic [1:0] load_a_v, load_q_v, add_en_v, dbl_v, neg_v, shift_en_v;
    logic [1:0] out_en_v, busy_v, done_v, aborted_v;
    logic [1:0][2:0] iter_v, st_v;

    int checks = 0;
    int errors = 0;
    logic [2:0] seq [0:4];

    always #5 clk = ~clk;

    // Instance 0: SKIP_ZERO=1, instance 1: SKIP_ZERO=0.
    booth_r4_seq_ctrl #(.OP_WIDTH(8), .SKIP_ZERO(1'b1)) dut_skip (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .abort(abort), .q_bits(qb[0]), .load_a(load_a_v[0]), .load_q(load_q_v[0]),
        .add_en(add_en_v[0]), .dbl(dbl_v[0]), .neg(neg_v[0]), .shift_en(shift_en_v[0]),
        .out_en(out_en_v[0]), .busy(busy_v[0]), .done(done_v[0]), .aborted(aborted_v[0]),
        .iter_cnt(iter_v[0]), .dbg_state(st_v[0])
    );

    booth_r4_seq_ctrl #(.OP_WIDTH(8), .SKIP_ZERO(1'b0)) dut_noskip (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .abort(abort), .q_bits(qb[1]), .load_a(load_a_v[1]), .load_q(load_q_v[1]),
        .add_en(add_en_v[1]), .dbl(dbl_v[1]), .neg(neg_v[1]), .shift_en(shift_en_v[1]),
        .out_en(out_en_v[1]), .busy(busy_v[1]), .done(done_v[1]), .aborted(aborted_v[1]),
        .iter_cnt(iter_v[1]), .dbg_state(st_v[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int all_outs(input int k);
        return int'({load_a_v[k], load_q_v[k], add_en_v[k], dbl_v[k], neg_v[k],
                     shift_en_v[k], out_en_v[k], busy_v[k], done_v[k], aborted_v[k],
                     iter_v[k], st_v[k]});
    endfunction

    // Booth digit value from the window {q1,q0,q-1}.
    function automatic int digit_of(input logic [2:0] w);
        return -2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
    endfunction

    task automatic run_op(input string name, input bit sm, input bit hold_start);
        int iters, nz, nd, nn;
        int idx[2], lat[2], adds[2], visits[2], shifts[2], ic[2], dbls[2], negs[2], abs_seen;
        bit fin[2];
        int cyc;
        iters = sm ? 4 : 5;
        nz = 0; nd = 0; nn = 0; abs_seen = 0;
        for (int i = 0; i < iters; i++) begin
            if (digit_of(seq[i]) != 0) nz++;
            if (digit_of(seq[i]) == 2 || digit_of(seq[i]) == -2) nd++;
            if (digit_of(seq[i]) < 0) nn++;
        end
        for (int k = 0; k < 2; k++) begin
            idx[k] = 0; lat[k] = 0; adds[k] = 0; visits[k] = 0; shifts[k] = 0;
            ic[k] = 0; dbls[k] = 0; negs[k] = 0; fin[k] = 1'b0; qb[k] = seq[0];
        end
        signed_mode = sm;
        start = 1'b1;
        cyc = 0;
        while (!(fin[0] && fin[1]) && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1 && !hold_start) start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (!fin[k]) begin
                    if (aborted_v[k]) abs_seen++;
                    if (st_v[k] == S_ADD) begin
                        visits[k]++;
                        check($sformatf("%s add_en[%0d]", name, k), int'(add_en_v[k]),
                              int'(digit_of(seq[idx[k]]) != 0));
                        check($sformatf("%s dbl[%0d]", name, k), int'(dbl_v[k]),
                              int'(digit_of(seq[idx[k]]) == 2 || digit_of(seq[idx[k]]) == -2));
                        check($sformatf("%s neg[%0d]", name, k), int'(neg_v[k]),
                              int'(digit_of(seq[idx[k]]) < 0));
                    end
                    if (add_en_v[k]) adds[k]++;
                    if (add_en_v[k] && dbl_v[k]) dbls[k]++;
                    if (add_en_v[k] && neg_v[k]) negs[k]++;
                    if (shift_en_v[k]) begin
                        shifts[k]++;
                        idx[k]++;
                        if (idx[k] < iters) qb[k] = seq[idx[k]];
                    end
                    if (done_v[k]) begin
                        fin[k] = 1'b1;
                        lat[k] = cyc;
                        ic[k] = int'(iter_v[k]);
                        check($sformatf("%s out_en[%0d]", name, k), int'(out_en_v[k]), 1);
                        start = 1'b0;
                    end
                end
            end
        end
        check({name, " latency skip"}, lat[0], 3 + 2 * iters + nz);
        check({name, " latency noskip"}, lat[1], 3 + 3 * iters);
        check({name, " add visits skip"}, visits[0], nz);
        check({name, " add visits noskip"}, visits[1], iters);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s add_en count[%0d]", name, k), adds[k], nz);
            check($sformatf("%s dbl count[%0d]", name, k), dbls[k], nd);
            check($sformatf("%s neg count[%0d]", name, k), negs[k], nn);
            check($sformatf("%s shifts[%0d]", name, k), shifts[k], iters);
            check($sformatf("%s iter_cnt at done[%0d]", name, k), ic[k], iters);
        end
        check({name, " no aborted"}, abs_seen, 0);
        @(posedge clk);
        #1;
        check({name, " idle after skip"}, int'(busy_v[0]), 0);
        check({name, " idle after noskip"}, int'(busy_v[1]), 0);
    endtask

    initial begin
        int rc, guard, dcount;
        qb = '0;
        // Reset state while rst is held.
        #2;
        check("reset outs skip", all_outs(0), 0);
        check("reset outs noskip", all_outs(1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle state", int'(st_v[0]), int'(S_IDLE));

        for (int i = 0; i < 5; i++) seq[i] = 3'b000;
        run_op("zeros", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) seq[i] = 3'b011;
        run_op("plus2", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) seq[i] = 3'($urandom_range(0, 7));
        run_op("unsigned", 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) seq[i] = 3'b100;
        run_op("minus2_u", 1'b0, 1'b0);
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 5; i++) seq[i] = 3'($urandom_range(0, 7));
            run_op($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Abort in the second RECODE of the zero-skip instance.
        qb = '0;
        signed_mode = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rc = 0;
        guard = 0;
        while (rc < 2 && guard < 40) begin
            if (st_v[0] == S_RECODE) rc++;
            if (rc < 2) begin
                @(posedge clk);
                #1;
            end
            guard++;
        end
        check("abort reached recode2", rc, 2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort state", int'(st_v[0]), int'(S_IDLE));
        check("abort pulse skip", int'(aborted_v[0]), 1);
        check("abort pulse noskip", int'(aborted_v[1]), 1);
        check("abort no done", int'(done_v[0]), 0);
        check("abort busy", int'(busy_v[0]), 0);
        @(posedge clk);
        #1;
        check("abort pulse width", int'(aborted_v[0]), 0);
        check("abort stays idle", int'(st_v[0]), int'(S_IDLE));
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort in idle ignored", int'(aborted_v[0]), 0);
        abort = 1'b0;
        for (int i = 0; i < 5; i++) seq[i] = 3'($urandom_range(0, 7));
        run_op("after_abort", 1'b1, 1'b0);

        // Asynchronous reset in the middle of a SHIFT cycle.
        qb = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!shift_en_v[0] && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("reached shift", int'(shift_en_v[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid-shift reset skip", all_outs(0), 0);
        check("mid-shift reset noskip", all_outs(1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            dcount += int'(done_v[0]) + int'(aborted_v[0]) + int'(busy_v[0]);
        end
        check("no activity after reset", dcount, 0);

        // start held through the whole operation must yield one operation.
        for (int i = 0; i < 5; i++) seq[i] = 3'($urandom_range(0, 7));
        run_op("held_start", 1'b1, 1'b1);
        dcount = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            dcount += int'(done_v[0]) + int'(busy_v[0]) + int'(done_v[1]) + int'(busy_v[1]);
        end
        check("single op for held start", dcount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
